vending_machine_multi: RTL and testbench

- Parametrised successor to the single-product-table vending FSM.
- Supports a configurable item count, a per-item price table and per-item stock counters.
- Handles sold-out detection and restock.
- Returns change serially as individual coins (largest first) rather than as a single lump value.
- Sits between the board coin/button decoders and the LED/7-seg display logic on PYNQ-Z2.

---
 rtl/vending_machine_multi.sv | 219 +++++++++++++++++++++
 tb/tb_vending_machine_multi.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/vending_machine_multi.sv
// Multi-item vending controller: per-item price table and stock counters,
// sold-out detection, restock, and serial largest-first change return.
module vending_machine_multi #(
  parameter int NUM_ITEMS  = 7,
  parameter int SEL_W      = 3,
  parameter int BAL_W      = 8,
  parameter int MAX_BAL    = 99,
  parameter logic [NUM_ITEMS*BAL_W-1:0] PRICES = 56'h32230A191E140F,
  parameter int STOCK_W    = 4,
  parameter int STOCK_INIT = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       coin,
  input  logic [SEL_W-1:0] item_sel,
  input  logic             cancel,
  input  logic             restock,
  output logic [BAL_W-1:0] balance,
  output logic [SEL_W-1:0] dispense,
  output logic [1:0]       change_coin,
  output logic [BAL_W-1:0] change_total,
  output logic             coin_reject,
  output logic             error,
  output logic             sold_out,
  output logic [2:0]       state_out
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_COLLECT = 3'd1,
    S_VEND    = 3'd2,
    S_CHANGE  = 3'd3
  } state_t;

  state_t           state_reg, state_next;
  logic [BAL_W-1:0] balance_reg, balance_next;
  logic [BAL_W-1:0] change_total_reg, change_total_next;
  logic [SEL_W-1:0] dispense_reg, dispense_next;
  logic [1:0]       change_coin_reg, change_coin_next;
  logic             coin_reject_reg, coin_reject_next;
  logic             error_reg, error_next;
  logic             sold_out_reg, sold_out_next;

  logic             vend_ok;
  logic             restock_ok;
  logic [BAL_W-1:0] coin_val;
  logic [BAL_W:0]   coin_sum;
  logic             sel_valid;
  logic [STOCK_W-1:0] sel_stock;
  logic [BAL_W-1:0] sel_price;
  logic [BAL_W-1:0] chg_amt;
  logic [1:0]       chg_code;

  logic [STOCK_W-1:0] stock_vec [NUM_ITEMS];
  logic [BAL_W-1:0]   price_vec [NUM_ITEMS];

  // One stock counter per item; item code gi+1 maps to slot gi.
  genvar gi;
  for (gi = 0; gi < NUM_ITEMS; gi++) begin : g_item
    logic [STOCK_W-1:0] stock_reg;
    assign price_vec[gi] = PRICES[gi*BAL_W +: BAL_W];
    assign stock_vec[gi] = stock_reg;
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        stock_reg <= STOCK_W'(STOCK_INIT);
      end else if (restock_ok) begin
        stock_reg <= STOCK_W'(STOCK_INIT);
      end else if (vend_ok && item_sel == SEL_W'(gi + 1)) begin
        stock_reg <= stock_reg - STOCK_W'(1);
      end
    end
  end

  always_comb begin
    sel_valid = 1'b0;
    sel_stock = '0;
    sel_price = '0;
    for (int i = 0; i < NUM_ITEMS; i++) begin
      if (item_sel == SEL_W'(i + 1)) begin
        sel_valid = 1'b1;
        sel_stock = stock_vec[i];
        sel_price = price_vec[i];
      end
    end
  end

  always_comb begin
    case (coin)
      2'b01:   coin_val = BAL_W'(5);
      2'b10:   coin_val = BAL_W'(10);
      2'b11:   coin_val = BAL_W'(20);
      default: coin_val = '0;
    endcase
    coin_sum = {1'b0, balance_reg} + {1'b0, coin_val};
  end

  // Largest coin that still fits in the remaining balance.
  always_comb begin
    if (balance_reg >= BAL_W'(20)) begin
      chg_amt  = BAL_W'(20);
      chg_code = 2'b11;
    end else if (balance_reg >= BAL_W'(10)) begin
      chg_amt  = BAL_W'(10);
      chg_code = 2'b10;
    end else if (balance_reg >= BAL_W'(5)) begin
      chg_amt  = BAL_W'(5);
      chg_code = 2'b01;
    end else begin
      chg_amt  = '0;
      chg_code = 2'b00;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg        <= S_IDLE;
      balance_reg      <= '0;
      change_total_reg <= '0;
      dispense_reg     <= '0;
      change_coin_reg  <= 2'b00;
      coin_reject_reg  <= 1'b0;
      error_reg        <= 1'b0;
      sold_out_reg     <= 1'b0;
    end else begin
      state_reg        <= state_next;
      balance_reg      <= balance_next;
      change_total_reg <= change_total_next;
      dispense_reg     <= dispense_next;
      change_coin_reg  <= change_coin_next;
      coin_reject_reg  <= coin_reject_next;
      error_reg        <= error_next;
      sold_out_reg     <= sold_out_next;
    end
  end

  always_comb begin
    state_next        = state_reg;
    balance_next      = balance_reg;
    change_total_next = change_total_reg;
    dispense_next     = '0;
    change_coin_next  = 2'b00;
    coin_reject_next  = 1'b0;
    error_next        = error_reg;
    sold_out_next     = sold_out_reg;
    vend_ok           = 1'b0;
    restock_ok        = 1'b0;

    case (state_reg)
      S_IDLE, S_COLLECT: begin
        if (cancel) begin
          error_next    = 1'b0;
          sold_out_next = 1'b0;
          if (balance_reg != '0) begin
            change_total_next = '0;
            state_next        = S_CHANGE;
          end else begin
            state_next = S_IDLE;
          end
        end else if (item_sel != '0) begin
          if (!sel_valid) begin
            error_next    = 1'b1;
            sold_out_next = 1'b0;
          end else if (sel_stock == '0) begin
            error_next    = 1'b1;
            sold_out_next = 1'b1;
          end else if (balance_reg < sel_price) begin
            error_next    = 1'b1;
            sold_out_next = 1'b0;
          end else begin
            balance_next      = balance_reg - sel_price;
            vend_ok           = 1'b1;
            dispense_next     = item_sel;
            error_next        = 1'b0;
            sold_out_next     = 1'b0;
            change_total_next = '0;
            state_next        = S_VEND;
          end
        end else if (coin != 2'b00) begin
          if (coin_sum <= (BAL_W+1)'(MAX_BAL)) begin
            balance_next  = coin_sum[BAL_W-1:0];
            error_next    = 1'b0;
            sold_out_next = 1'b0;
            state_next    = S_COLLECT;
          end else begin
            coin_reject_next = 1'b1;
          end
        end else if (restock && state_reg == S_IDLE) begin
          restock_ok = 1'b1;
        end
      end

      S_VEND: begin
        state_next = (balance_reg != '0) ? S_CHANGE : S_IDLE;
      end

      S_CHANGE: begin
        if (balance_reg == '0) begin
          state_next = S_IDLE;
        end else begin
          change_coin_next  = chg_code;
          balance_next      = balance_reg - chg_amt;
          change_total_next = change_total_reg + chg_amt;
        end
      end

      default: state_next = S_IDLE;
    endcase
  end

  assign balance      = balance_reg;
  assign dispense     = dispense_reg;
  assign change_coin  = change_coin_reg;
  assign change_total = change_total_reg;
  assign coin_reject  = coin_reject_reg;
  assign error        = error_reg;
  assign sold_out     = sold_out_reg;
  assign state_out    = state_reg;

endmodule

// File: tb/tb_vending_machine_multi.sv
// Scoreboard bench: stimulus predicts pulses/status from a transaction-level
// model; separate monitors pop and compare as the DUT presents them.
module tb_vending_machine_multi;
  localparam int NUM_ITEMS  = 7;
  localparam int SEL_W      = 3;
  localparam int BAL_W      = 8;
  localparam int MAX_BAL    = 99;
  localparam int STOCK_INIT = 5;

  localparam int EV_DISP = 1;
  localparam int EV_COIN = 2;
  localparam int EV_REJ  = 3;

  logic             clk = 1'b0;
  logic             reset;
  logic [1:0]       coin;
  logic [SEL_W-1:0] item_sel;
  logic             cancel;
  logic             restock;
  logic [BAL_W-1:0] balance;
  logic [SEL_W-1:0] dispense;
  logic [1:0]       change_coin;
  logic [BAL_W-1:0] change_total;
  logic             coin_reject;
  logic             error;
  logic             sold_out;
  logic [2:0]       state_out;

  vending_machine_multi dut (
    .clk(clk), .reset(reset), .coin(coin), .item_sel(item_sel),
    .cancel(cancel), .restock(restock), .balance(balance),
    .dispense(dispense), .change_coin(change_coin),
    .change_total(change_total), .coin_reject(coin_reject),
    .error(error), .sold_out(sold_out), .state_out(state_out)
  );

  always #5 clk = ~clk;

  typedef struct { int kind; int val; int bal; } ev_t;
  typedef struct { int bal; int st; int err; int so; int ct; } st_t;

  ev_t  ev_q[$];
  st_t  st_q[$];
  event status_ev;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: credit, stock per item, flags, last refund total.
  int price_tab [NUM_ITEMS+1] = '{0, 15, 20, 30, 25, 10, 35, 50};
  int m_stock   [NUM_ITEMS+1];
  int m_bal, m_err, m_so, m_ct;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic take_event(input int kind, input int val, input int bal);
    ev_t e;
    if (ev_q.size() == 0) begin
      check("unexpected_event_kind", kind, 0);
    end else begin
      e = ev_q.pop_front();
      check("event_kind", kind, e.kind);
      check("event_value", val, e.val);
      if (e.bal >= 0) check("event_balance", bal, e.bal);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (dispense != '0)     take_event(EV_DISP, int'(dispense), int'(balance));
      if (change_coin != 2'b00) take_event(EV_COIN, int'(change_coin), -1);
      if (coin_reject)        take_event(EV_REJ, 0, int'(balance));
    end
  end

  always @(status_ev) begin
    st_t s;
    if (st_q.size() == 0) begin
      check("status_queue_underflow", 1, 0);
    end else begin
      s = st_q.pop_front();
      check("balance", int'(balance), s.bal);
      check("state_out", int'(state_out), s.st);
      check("error", int'(error), s.err);
      check("sold_out", int'(sold_out), s.so);
      check("change_total", int'(change_total), s.ct);
    end
  end

  function automatic int coin_value(input int c);
    return (c == 1) ? 5 : (c == 2) ? 10 : (c == 3) ? 20 : 0;
  endfunction

  // Greedy payout of the model balance; returns cycles spent in CHANGE.
  function automatic int refund();
    int n = 0;
    int v;
    while (m_bal > 0) begin
      v = (m_bal >= 20) ? 20 : (m_bal >= 10) ? 10 : 5;
      ev_q.push_back('{EV_COIN, (v == 20) ? 3 : (v == 10) ? 2 : 1, -1});
      m_bal -= v;
      m_ct  += v;
      n++;
    end
    return n + 1;
  endfunction

  task automatic model_reset();
    m_bal = 0; m_err = 0; m_so = 0; m_ct = 0;
    for (int i = 1; i <= NUM_ITEMS; i++) m_stock[i] = STOCK_INIT;
  endtask

  task automatic txn(input int c, input int s, input bit can, input bit rs);
    int settle = 0;
    int v;
    @(negedge clk);
    coin = 2'(c); item_sel = SEL_W'(s); cancel = can; restock = rs;
    if (can) begin
      m_err = 0; m_so = 0;
      if (m_bal > 0) begin
        m_ct = 0;
        settle = refund();
      end
    end else if (s != 0) begin
      if (m_stock[s] == 0) begin
        m_err = 1; m_so = 1;
      end else if (m_bal < price_tab[s]) begin
        m_err = 1; m_so = 0;
      end else begin
        m_bal -= price_tab[s];
        m_stock[s]--;
        m_err = 0; m_so = 0; m_ct = 0;
        ev_q.push_back('{EV_DISP, s, m_bal});
        settle = (m_bal > 0) ? 1 + refund() : 1;
      end
    end else if (c != 0) begin
      v = coin_value(c);
      if (m_bal + v <= MAX_BAL) begin
        m_bal += v; m_err = 0; m_so = 0;
      end else begin
        ev_q.push_back('{EV_REJ, 0, m_bal});
      end
    end else if (rs && m_bal == 0) begin
      for (int i = 1; i <= NUM_ITEMS; i++) m_stock[i] = STOCK_INIT;
    end
    @(negedge clk);
    coin = 2'b00; item_sel = '0; cancel = 1'b0; restock = 1'b0;
    repeat (settle) @(negedge clk);
    #1;
    st_q.push_back('{m_bal, (m_bal > 0) ? 1 : 0, m_err, m_so, m_ct});
    -> status_ev;
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; coin = 2'b00; item_sel = '0; cancel = 1'b0; restock = 1'b0;
    model_reset();
    #1;
    check("reset_balance", int'(balance), 0);
    check("reset_state", int'(state_out), 0);
    check("reset_dispense", int'(dispense), 0);
    check("reset_change_coin", int'(change_coin), 0);
    check("reset_change_total", int'(change_total), 0);
    check("reset_flags", int'({coin_reject, error, sold_out}), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Directed scenarios from the feature list.
    txn(2, 0, 0, 0); txn(0, 1, 0, 0);                 // too little credit
    txn(0, 0, 1, 0);
    txn(3, 0, 0, 0); txn(3, 0, 0, 0); txn(0, 3, 0, 0); // vend with change
    for (int i = 0; i < 5; i++) txn(3, 0, 0, 0);      // fifth coin rejected
    txn(0, 0, 1, 0);
    for (int i = 0; i < 5; i++) begin txn(2, 0, 0, 0); txn(0, 5, 0, 0); end
    txn(2, 0, 0, 0); txn(0, 5, 0, 0);                 // sold out
    txn(0, 0, 1, 0);
    txn(0, 0, 0, 1); txn(2, 0, 0, 0); txn(0, 5, 0, 0); // restock, buy again
    txn(1, 0, 0, 0); txn(2, 0, 0, 0); txn(3, 0, 0, 0); txn(0, 0, 1, 0);
    txn(0, 0, 1, 0);                                  // cancel at zero
    txn(2, 2, 1, 1);                                  // priority: cancel wins

    for (int n = 0; n < 400; n++) begin
      txn($urandom_range(0, 3),
          ($urandom_range(0, 3) == 0) ? $urandom_range(1, NUM_ITEMS) : 0,
          ($urandom_range(0, 11) == 0),
          ($urandom_range(0, 24) == 0));
    end

    // Reset during the second change cycle aborts the refund.
    txn(0, 0, 1, 0);
    for (int i = 0; i < 3; i++) txn(3, 0, 0, 0);
    @(negedge clk); cancel = 1'b1;
    @(negedge clk); cancel = 1'b0;
    ev_q.push_back('{EV_COIN, 3, -1});
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("abort_balance", int'(balance), 0);
    check("abort_state", int'(state_out), 0);
    check("abort_change_coin", int'(change_coin), 0);
    check("abort_change_total", int'(change_total), 0);
    check("abort_outputs", int'({dispense, coin_reject, error, sold_out}), 0);
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    txn(0, 0, 0, 0);

    for (int n = 0; n < 150; n++) begin
      txn($urandom_range(0, 3),
          ($urandom_range(0, 2) == 0) ? $urandom_range(1, NUM_ITEMS) : 0,
          ($urandom_range(0, 11) == 0),
          ($urandom_range(0, 29) == 0));
    end

    repeat (4) @(negedge clk);
    check("pending_events", ev_q.size(), 0);
    check("pending_status", st_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
